vram_fetch: RTL

Video-side read sequencer for the shared video RAM. It drives the read-only port of the dual-port video RAM with a burst of sequential addresses and absorbs the one-cycle RAM read latency. Returned bytes are buffered in a small FIFO and handed to the downstream pixel shifter through a valid/ready handshake. The line-parameter logic issues one burst per fetch request (start address plus byte count).

---
 rtl/vram_fetch_pkg.sv | 19 +
 rtl/vram_fetch_fifo.sv | 69 ++++++
 rtl/vram_fetch.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vram_fetch_pkg.sv
// ---------------------------------------------------------------------------
// vram_fetch_pkg
// Shared video package: sequencer state encoding, segment size for the
// optional segment-wrap addressing, and default widths for vram_fetch.
// ---------------------------------------------------------------------------
package vram_fetch_pkg;

    localparam int unsigned DEF_AW   = 16;  // RAM address width (64 KB)
    localparam int unsigned DEF_FD   = 3;   // log2 FIFO depth (8 entries)
    localparam int unsigned DEF_CW   = 10;  // burst length width
    localparam int unsigned SEG_BITS = 14;  // 16 KB segment

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/vram_fetch_fifo.sv
// ---------------------------------------------------------------------------
// vram_fetch_fifo
// Synchronous FIFO, 2^FD entries of W bits, with synchronous flush.
// Ports:
//   clock_i  clock
//   reset_i  asynchronous active-high reset
//   flush_i  empties the FIFO on the next edge; beats push and pop
//   push_i   write din_i (caller guarantees no overflow)
//   din_i    write data
//   pop_i    drop head entry; ignored when empty
//   dout_o   head entry, 0 when empty
//   empty_o  no entries
//   count_o  occupancy, 0..2^FD
// ---------------------------------------------------------------------------
module vram_fetch_fifo #(
    parameter int unsigned FD = 3,
    parameter int unsigned W  = 8
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          empty_o,
    output logic [FD:0]   count_o
);

    localparam int unsigned DEPTH = 1 << FD;

    logic [W-1:0]  mem_q [DEPTH];
    logic [FD-1:0] wr_q;
    logic [FD-1:0] rd_q;
    logic [FD:0]   count_q;
    logic          do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + FD'(1);
            if (do_pop) rd_q <= rd_q + FD'(1);
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + (FD+1)'(1);
                2'b01:   count_q <= count_q - (FD+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage, no reset needed: contents are only visible when occupied.
    always_ff @(posedge clock_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/vram_fetch.sv
// ---------------------------------------------------------------------------
// vram_fetch
// Video-side burst read sequencer for the dual-port video RAM. Issues
// sequential reads, absorbs the one-cycle RAM latency through an in-flight
// flag, and buffers returned bytes in a FIFO feeding a valid/ready consumer.
// Optional macro VRAM_FETCH_SEGWRAP_EN: address increments only within its
// 16 KB segment (upper bits hold the base value).
// Ports:
//   clock_i  clock, shared with the RAM read port
//   reset_i  asynchronous active-high reset
//   start_i  one-cycle burst request, honoured only in IDLE
//   abort_i  synchronous cancel, priority over start_i
//   base_i   first byte address (sampled with start_i)
//   len_i    byte count (sampled with start_i), 0 legal
//   busy_o   state is not IDLE
//   done_o   one-cycle pulse once the burst has landed in the FIFO
//   a_o      registered RAM read address
//   q_i      RAM read data, valid the cycle after a_o
//   data_o   FIFO head byte
//   valid_o  FIFO not empty
//   ready_i  downstream accept
// ---------------------------------------------------------------------------
module vram_fetch
    import vram_fetch_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned FD = DEF_FD,
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [AW-1:0] base_i,
    input  logic [CW-1:0] len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] a_o,
    input  logic [7:0]    q_i,
    output logic [7:0]    data_o,
    output logic          valid_o,
    input  logic          ready_i
);

    localparam int unsigned DEPTH = 1 << FD;
    localparam int unsigned OW    = FD + 2;

    state_t        state_q;
    logic [CW-1:0] rem_q;
    logic          infl_q;
    logic [AW-1:0] a_q;
    logic          busy_q;
    logic          done_q;

    logic [FD:0]   fifo_count;
    logic          fifo_empty;
    logic [OW-1:0] occ;
    logic          issue;
    logic [AW-1:0] a_inc_d;

    // Reserve a FIFO slot for every read still in flight so push never overflows.
    assign occ   = OW'(fifo_count) + OW'(infl_q);
    assign issue = (state_q == FETCH) && (rem_q != '0) && (occ < OW'(DEPTH));

`ifdef VRAM_FETCH_SEGWRAP_EN
    localparam logic [AW-1:0] SEG_MASK = AW'((32'd1 << SEG_BITS) - 32'd1);
    // Carry out of the segment offset is dropped; segment bits hold.
    assign a_inc_d = (a_q & ~SEG_MASK) | ((a_q + AW'(1)) & SEG_MASK);
`else
    assign a_inc_d = a_q + AW'(1);
`endif

    // Sequencer FSM, address/length counters and in-flight flag.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            infl_q  <= 1'b0;
            a_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            infl_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            infl_q <= issue;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        rem_q  <= len_i;
                        if (len_i == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            a_q     <= base_i;
                            state_q <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        a_q   <= a_inc_d;
                        rem_q <= rem_q - CW'(1);
                        if (rem_q == CW'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last read (if any) lands during the first DRAIN cycle.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    vram_fetch_fifo #(
        .FD (FD),
        .W  (8)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush_i (abort_i),
        .push_i  (infl_q),
        .din_i   (q_i),
        .pop_i   (ready_i),
        .dout_o  (data_o),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign a_o     = a_q;
    assign valid_o = !fifo_empty;

endmodule
